// File: rtl/cpu_pipe_pkg.sv
// Shared constants and helpers for the CPU datapath pipeline registers.
package cpu_pipe_pkg;

  // An illegal select captures an all-zero word rather than an arbitrary input.
  localparam bit SEL_ZERO_ON_ERR = 1'b1;

  // $clog2 with a floor of 1 bit, so one-input and one-stage cases still have real ports.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pipe_stage.sv
// One pipeline slot: a data register plus its valid bit.
module pipe_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             clr,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] data_in,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  // A clear drops the valid bit only; data holds, so a flushed slot keeps its stale word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (clr) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= valid_in;
      if (valid_in) begin
        data <= data_in;
      end
    end
  end

endmodule

// File: rtl/sel_pipe_register.sv
// Input select mux feeding a DEPTH-stage valid/ready pipeline register chain
// with bubble collapsing, synchronous flush and an illegal-select flag.
module sel_pipe_register
  import cpu_pipe_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  parameter int DEPTH  = 2,
  parameter int SEL_W  = clog2_min1(NUM_IN),
  parameter int CNT_W  = clog2_min1(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    flush,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [CNT_W-1:0]        count,
  output logic                    sel_err
);

  // Handshake: a beat transfers on a rising edge where valid && ready are both high.
  // ready never depends on valid; in_ready is combinational from out_ready and flush.

  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] v_in;
  logic [DEPTH-1:0] v_next;
  logic [DEPTH-1:0] adv;
  logic [WIDTH-1:0] d    [DEPTH];
  logic [WIDTH-1:0] d_in [DEPTH];
  logic [WIDTH-1:0] sel_word;
  logic             sel_legal;
  logic [CNT_W-1:0] cnt_next;

  always_comb begin
    sel_legal = 1'b0;
    sel_word  = SEL_ZERO_ON_ERR ? '0 : in_data[WIDTH-1:0];
    for (int i = 0; i < NUM_IN; i++) begin
      if (sel == SEL_W'(i)) begin
        sel_legal = 1'b1;
        sel_word  = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // A stage advances when it is empty or the stage after it advances (bubble collapse).
  always_comb begin
    logic a;
    a   = out_ready;
    adv = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      a      = ~v[k] | a;
      adv[k] = a;
    end
  end

  assign in_ready = adv[0] & ~flush;

  assign v_in[0] = in_valid;
  assign d_in[0] = sel_word;

  for (genvar k = 1; k < DEPTH; k++) begin : g_link
    assign v_in[k] = v[k-1];
    assign d_in[k] = d[k-1];
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    pipe_stage #(.WIDTH(WIDTH)) u_stage (
      .clk      (clk),
      .rst      (rst),
      .load     (adv[k] & ~flush),
      .clr      (flush),
      .valid_in (v_in[k]),
      .data_in  (d_in[k]),
      .valid    (v[k]),
      .data     (d[k])
    );
  end

  // Next-state valids mirror the stage update rule so count tracks occupancy after the edge.
  always_comb begin
    v_next   = '0;
    cnt_next = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (flush)       v_next[k] = 1'b0;
      else if (adv[k]) v_next[k] = v_in[k];
      else             v_next[k] = v[k];
      cnt_next = cnt_next + CNT_W'(v_next[k]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count   <= '0;
      sel_err <= 1'b0;
    end else begin
      count   <= cnt_next;
      sel_err <= in_ready & in_valid & ~sel_legal;
    end
  end

  assign out_data  = d[DEPTH-1];
  assign out_valid = v[DEPTH-1];

endmodule

// File: tb/tb_sel_pipe_register.sv
// Bench for sel_pipe_register: directed scenarios plus random traffic,
// checked by an expected-word queue and an occupancy/age reference model.
module tb_sel_pipe_register;

  localparam int W  = 32;
  localparam int NI = 3;
  localparam int DP = 3;
  localparam int SW = 2;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [NI*W-1:0] in_data = '0;
  logic [SW-1:0] sel = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          flush = 1'b0;
  logic [W-1:0]  out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [CW-1:0] count;
  logic          sel_err;

  sel_pipe_register #(.WIDTH(W), .NUM_IN(NI), .DEPTH(DP)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .flush     (flush),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count),
    .sel_err   (sel_err)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int           stamp_q[$];
  int           cyc = 0;
  int           occ = 0;
  logic         err_pend = 1'b0;
  int           n_vec = 0;
  int           n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  function automatic logic [NI*W-1:0] rnd_in();
    return {$urandom, $urandom, $urandom};
  endfunction

  task automatic drive(input logic v, input logic [SW-1:0] s, input logic [NI*W-1:0] d,
                       input logic ordy, input logic fl, output logic acc);
    logic [W-1:0] word;
    int idx;
    @(posedge clk);
    #2;
    in_valid  = v;
    sel       = s;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    #1;
    acc = v && in_ready && !rst;
    if (acc) begin
      idx  = s;
      word = (idx < NI) ? d[idx*W +: W] : '0;
      exp_q.push_back(word);
      stamp_q.push_back(cyc);
    end
  endtask

  task automatic idle(input logic ordy);
    logic acc;
    drive(1'b0, '0, rnd_in(), ordy, 1'b0, acc);
  endtask

  task automatic send(input logic [SW-1:0] s, input logic [NI*W-1:0] d, input logic ordy);
    logic acc;
    int n;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 20) begin
      drive(1'b1, s, d, ordy, 1'b0, acc);
      n++;
    end
    n_vec++;
    if (!acc) begin
      n_err++;
      $display("FAIL send_timeout: accepted=%0d required=1", acc);
    end
  endtask

  // ---------------- monitor ----------------
  // Oldest word sits in the last stage once it has seen DP edges (accept edge included).
  always @(negedge clk) begin
    logic exp_rdy;
    logic exp_ov;
    if (rst) begin
      check("rst_out_valid", out_valid, 0);
      check("rst_count", count, 0);
      check("rst_sel_err", sel_err, 0);
      check("rst_out_data", out_data, 0);
      exp_q.delete();
      stamp_q.delete();
      occ      = 0;
      err_pend = 1'b0;
    end else begin
      exp_rdy = !flush && (occ < DP || out_ready);
      exp_ov  = 1'b0;
      if (exp_q.size() > 0) exp_ov = (cyc - stamp_q[0]) >= DP;
      check("count", count, occ);
      check("in_ready", in_ready, exp_rdy);
      check("out_valid", out_valid, exp_ov);
      check("sel_err", sel_err, err_pend);
      if (exp_ov && out_ready && !flush) begin
        check("out_data", out_data, exp_q[0]);
        void'(exp_q.pop_front());
        void'(stamp_q.pop_front());
      end
      if (flush) begin
        exp_q.delete();
        stamp_q.delete();
        occ = 0;
      end else begin
        occ = occ + int'(in_valid && exp_rdy) - int'(exp_ov && out_ready);
      end
      err_pend = in_valid && exp_rdy && (int'(sel) >= NI);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic acc;
    int n;

    // reset
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;

    // legal selects, 1/3/5 on slots 0/1/2
    drive(1'b1, 2'd0, {32'd5, 32'd3, 32'd1}, 1'b1, 1'b0, acc);
    drive(1'b1, 2'd2, {32'd5, 32'd3, 32'd1}, 1'b1, 1'b0, acc);
    drive(1'b1, 2'd1, {32'd5, 32'd3, 32'd1}, 1'b1, 1'b0, acc);
    repeat (5) idle(1'b1);

    // backpressure: three fill, fourth held upstream
    for (int i = 0; i < 3; i++) drive(1'b1, SW'(i), rnd_in(), 1'b0, 1'b0, acc);
    repeat (3) drive(1'b1, 2'd1, rnd_in(), 1'b0, 1'b0, acc);
    send(2'd2, rnd_in(), 1'b1);
    repeat (6) idle(1'b1);

    // bubble collapse, then fill and flush with a word presented
    drive(1'b1, 2'd0, rnd_in(), 1'b0, 1'b0, acc);
    repeat (4) idle(1'b0);
    drive(1'b1, 2'd1, rnd_in(), 1'b0, 1'b0, acc);
    drive(1'b1, 2'd2, rnd_in(), 1'b0, 1'b0, acc);
    drive(1'b1, 2'd2, rnd_in(), 1'b0, 1'b1, acc);
    repeat (2) idle(1'b0);

    // illegal select accepted, then illegal select refused by a full pipe
    drive(1'b1, 2'd3, rnd_in(), 1'b1, 1'b0, acc);
    repeat (5) idle(1'b1);
    for (int i = 0; i < 3; i++) drive(1'b1, 2'd0, rnd_in(), 1'b0, 1'b0, acc);
    repeat (2) drive(1'b1, 2'd3, rnd_in(), 1'b0, 1'b0, acc);
    drive(1'b0, 2'd0, rnd_in(), 1'b0, 1'b1, acc);
    idle(1'b1);

    // asynchronous reset with a full, stalled pipe
    for (int i = 0; i < 3; i++) drive(1'b1, SW'(i), rnd_in(), 1'b0, 1'b0, acc);
    idle(1'b0);
    rst = 1'b1;
    #1;
    check("async_out_valid", out_valid, 0);
    check("async_count", count, 0);
    check("async_out_data", out_data, 0);
    @(posedge clk);
    #2 rst = 1'b0;
    send(2'd1, rnd_in(), 1'b1);
    repeat (4) idle(1'b1);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, SW'($urandom_range(0, 3)), rnd_in(),
            $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, acc);
    end

    // drain
    n = 0;
    while (exp_q.size() > 0 && n < 30) begin
      idle(1'b1);
      n++;
    end
    idle(1'b1);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d words left, required 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
